alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Execute stage that consumes the 16-bit output of the 8:1 register-select mux.
- Drives the mux select itself, in two phases:
  - Phase 1 selects the first operand register and captures it into operand register s.
  - Phase 2 selects the second operand, computes s op t and registers the result c.
- Then issues a one-cycle write-back request of c into register rx.
- Sits between the register-file/mux and the register-file write port; sequenced by the control unit through start/done.

Parameters:
- WIDTH, 16, datapath width; must match mux data width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to execute one instruction; sampled only in IDLE
- alu_sel  input  4  opcode, sampled with start
- rx  input  3  first operand register index; also the write-back destination; sampled with start
- ry  input  3  second operand register index; sampled with start
- mux_sel  output  3  select driven to the mux
- mux_out  input  WIDTH  data returned by the mux for the current mux_sel (combinational path)
- result  output  WIDTH  register c; holds the last computed value
- carry  output  1  carry/borrow/overflow flag of the last op
- zero  output  1  high when c == 0 after the last op
- busy  output  1  high in any non-IDLE state
- done  output  1  one-cycle pulse in WB
- wr_en  output  1  one-cycle register-file write strobe in WB
- wr_addr  output  3  write-back destination; equals latched rx

Behaviour:
- Reset values: state=IDLE, s=0, c=0, carry=0, zero=0, busy=0, done=0, wr_en=0, wr_addr=0, mux_sel=0, latched rx/ry/alu_sel=0.
- Reset has priority over every other input, including mid-operation: any state returns to IDLE next edge and no write-back is issued.
- FSM states: IDLE -> LOAD_S -> LOAD_C -> WB -> IDLE.
- IDLE:
  - mux_sel=0.
  - If start=1, latch alu_sel/rx/ry and go to LOAD_S.
  - start is ignored in every other state; no queuing.
- LOAD_S: mux_sel=rx_l; at the edge, s <= mux_out.
- LOAD_C:
  - mux_sel=ry_l; at the edge, c <= f(s, t) with t=mux_out; carry and zero update from the new c.
- WB:
  - mux_sel=rx_l; wr_en=1, done=1, wr_addr=rx_l; result already equals the new c.
  - Next state is IDLE. A start asserted during WB is not accepted; it must be held into IDLE.
- Latency and throughput: start sampled at edge N; done/wr_en high during cycle N+3; a new start is accepted at edge N+4 at the earliest (one instruction per 4 cycles).
- Opcodes (all arithmetic is unsigned, modulo 2^WIDTH):
  - 0 ADD: c=s+t; carry = bit 16 of the 17-bit sum.
  - 1 SUB: c=s-t; carry = borrow (s<t).
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0.
  - 5 SHL: c = s << t[3:0]; carry=0; t[15:4] ignored.
  - 6 SHR: logical; c = s >> t[3:0]; carry=0.
  - 7 CMP: c = 0 if s==t, 1 if s>t, 2 if s<t; carry=0.
  - 8 MUL: see Optional Feature.
  - 9-15: reserved; c=0, carry=0, zero=1; write-back still occurs.
- rx==ry is legal; both phases read the same register.
- busy = (state != IDLE); done and wr_en are never high outside WB.
- result, carry and zero hold their values until the next LOAD_C edge or reset.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 8 = MUL.
  - c = low WIDTH bits of s*t.
  - carry = 1 if the upper WIDTH bits of the product are nonzero.
  - Single-cycle combinational multiply in LOAD_C; latency unchanged.
- Undefined: opcode 8 is reserved (c=0, carry=0, zero=1); no multiplier is synthesised.

Test Plan:
- ADD with carry: reg3=0xFFFF, reg5=0x0002, start with alu_sel=0, rx=3, ry=5.
  - mux_sel 3 then 5.
  - During cycle N+3: result=0x0001, carry=1, zero=0, wr_en=1, wr_addr=3, done=1.
- SUB and zero flag:
  - s=0x1234, t=0x1234 -> c=0x0000, zero=1, carry=0.
  - s=0x0001, t=0x0002 -> c=0xFFFF, carry=1.
- Shift and CMP:
  - SHL, s=0x0001, t=0x0013 (amount 3) -> c=0x0008.
  - CMP, s=5, t=9 -> c=2; CMP, s=9, t=5 -> c=1; CMP, s=t -> c=0.
- Handshake:
  - start held high continuously -> done pulses every 4 cycles, exactly one wr_en per instruction.
  - start pulsed while busy=1 is ignored.
  - rx=ry=4 with reg4=0x0003, ADD -> c=0x0006.
- Reset mid-op:
  - Assert reset in LOAD_C -> next cycle state IDLE, busy=0, c=0, and no wr_en at any point.
- Opcode 8: s=0x0100, t=0x0100.
  - With ALU_MUL_EN: c=0x0000, carry=1, zero=1.
  - Without it: c=0, carry=0, zero=1.
  - With ALU_MUL_EN, s=3, t=7 -> c=0x0015, carry=0.

Source files
------------

// File: rtl/alu_stage.sv
// Two-phase execute stage: reads operand s then t through the register-select mux,
// registers c = s op t, then issues a one-cycle write-back of c to rx.
// Optional multiplier on opcode 8 enabled by defining ALU_MUL_EN.
module alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic [2:0]       rx,
    input  logic [2:0]       ry,
    output logic [2:0]       mux_sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [2:0]       wr_addr
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD_S, LOAD_C, WB} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_c;
    logic             r_carry;
    logic             r_zero;
    logic [2:0]       r_rx;
    logic [2:0]       r_ry;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] w_c;
    logic             w_carry;
    logic [WIDTH:0]   w_sum;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_c     <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_rx    <= '0;
            r_ry    <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_op <= alu_sel;
                r_rx <= rx;
                r_ry <= ry;
            end
            if (r_state == LOAD_S) begin
                r_s <= mux_out;
            end
            if (r_state == LOAD_C) begin
                r_c     <= w_c;
                r_carry <= w_carry;
                r_zero  <= (w_c == '0);
            end
        end
    end

    // Sequencing and mux steering; WB re-selects rx so the mux points at the destination.
    always_comb begin
        w_next  = r_state;
        mux_sel = 3'd0;
        busy    = 1'b1;
        done    = 1'b0;
        wr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = LOAD_S;
                end
            end
            LOAD_S: begin
                mux_sel = r_rx;
                w_next  = LOAD_C;
            end
            LOAD_C: begin
                mux_sel = r_ry;
                w_next  = WB;
            end
            WB: begin
                mux_sel = r_rx;
                done    = 1'b1;
                wr_en   = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_sum   = {1'b0, r_s} + {1'b0, mux_out};
        w_c     = '0;
        w_carry = 1'b0;
`ifdef ALU_MUL_EN
        w_prod  = {{WIDTH{1'b0}}, r_s} * {{WIDTH{1'b0}}, mux_out};
`endif
        case (r_op)
            4'd0: begin
                w_c     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            4'd1: begin
                w_c     = r_s - mux_out;
                w_carry = (r_s < mux_out);
            end
            4'd2: w_c = r_s & mux_out;
            4'd3: w_c = r_s | mux_out;
            4'd4: w_c = r_s ^ mux_out;
            4'd5: w_c = r_s << mux_out[SHW-1:0];
            4'd6: w_c = r_s >> mux_out[SHW-1:0];
            4'd7: begin
                if (r_s == mux_out) begin
                    w_c = '0;
                end else if (r_s > mux_out) begin
                    w_c = WIDTH'(1);
                end else begin
                    w_c = WIDTH'(2);
                end
            end
`ifdef ALU_MUL_EN
            4'd8: begin
                w_c     = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                w_c     = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    assign result  = r_c;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign wr_addr = r_rx;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: models the register file behind the mux and
// scoreboards each instruction's write-back against a reference ALU model.
module tb_alu_stage;

    typedef struct {
        logic [15:0] c;
        logic        carry;
        logic        zero;
        logic [2:0]  addr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_sel;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  mux_sel;
    logic [15:0] mux_out;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [2:0]  wr_addr;

    logic [15:0] regs [8];
    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          wrSeen      = 0;
    int          wrExpected  = 0;
    logic [15:0] lastC       = 16'h0;

    alu_stage #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_sel (alu_sel),
        .rx      (rx),
        .ry      (ry),
        .mux_sel (mux_sel),
        .mux_out (mux_out),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr)
    );

    assign mux_out = regs[mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) wrSeen++;
    end

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] s,
                                   input logic [15:0] t, input logic [2:0] addr);
        exp_t        e;
        logic [16:0] wide;
        logic [31:0] prod;
        e.c     = 16'h0;
        e.carry = 1'b0;
        wide    = 17'(s) + 17'(t);
        prod    = 32'(s) * 32'(t);
        case (op)
            4'd0: begin e.c = wide[15:0]; e.carry = wide[16]; end
            4'd1: begin e.c = s - t; e.carry = (t > s); end
            4'd2: e.c = s & t;
            4'd3: e.c = s | t;
            4'd4: e.c = s ^ t;
            4'd5: e.c = s << t[3:0];
            4'd6: e.c = s >> t[3:0];
            4'd7: e.c = (s == t) ? 16'd0 : ((s > t) ? 16'd1 : 16'd2);
`ifdef ALU_MUL_EN
            4'd8: begin e.c = prod[15:0]; e.carry = (prod > 32'h0000_FFFF); end
`endif
            default: begin e.c = 16'h0; e.carry = 1'b0; end
        endcase
        e.zero = (e.c == 16'h0);
        e.addr = addr;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge inside WB: pops the oldest expectation and compares it.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ":sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ":done"},    32'(done),    32'd1);
            check({tag, ":wr_en"},   32'(wr_en),   32'd1);
            check({tag, ":wr_addr"}, 32'(wr_addr), 32'(e.addr));
            check({tag, ":mux_wb"},  32'(mux_sel), 32'(e.addr));
            check({tag, ":result"},  32'(result),  32'(e.c));
            check({tag, ":carry"},   32'(carry),   32'(e.carry));
            check({tag, ":zero"},    32'(zero),    32'(e.zero));
            lastC = e.c;
        end
    endtask

    // Issues one instruction from IDLE (at a negedge) and follows it through all phases.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] x,
                                 input logic [2:0] y, input string tag);
        sb.push_back(model(op, regs[x], regs[y], x));
        wrExpected++;
        start   = 1'b1;
        alu_sel = op;
        rx      = x;
        ry      = y;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":mux_s"},  32'(mux_sel), 32'(x));
        check({tag, ":busy1"},  32'(busy),    32'd1);
        check({tag, ":done1"},  32'(done),    32'd0);
        @(negedge clk);
        check({tag, ":mux_t"},  32'(mux_sel), 32'(y));
        check({tag, ":wr_en2"}, 32'(wr_en),   32'd0);
        @(negedge clk);
        checkOutput(tag);
        @(negedge clk);
        check({tag, ":busy4"},  32'(busy),    32'd0);
        check({tag, ":done4"},  32'(done),    32'd0);
        check({tag, ":wr_en4"}, 32'(wr_en),   32'd0);
        check({tag, ":mux_i"},  32'(mux_sel), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        alu_sel = 4'd0;
        rx      = 3'd0;
        ry      = 3'd0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        repeat (2) @(negedge clk);
        check("rst:busy",    32'(busy),    32'd0);
        check("rst:done",    32'(done),    32'd0);
        check("rst:wr_en",   32'(wr_en),   32'd0);
        check("rst:wr_addr", 32'(wr_addr), 32'd0);
        check("rst:mux_sel", 32'(mux_sel), 32'd0);
        check("rst:result",  32'(result),  32'd0);
        check("rst:carry",   32'(carry),   32'd0);
        check("rst:zero",    32'(zero),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        regs[3] = 16'hFFFF; regs[5] = 16'h0002;
        applyStimulus(4'd0, 3'd3, 3'd5, "add_carry");
        regs[1] = 16'h1234; regs[2] = 16'h1234;
        applyStimulus(4'd1, 3'd1, 3'd2, "sub_zero");
        regs[1] = 16'h0001; regs[2] = 16'h0002;
        applyStimulus(4'd1, 3'd1, 3'd2, "sub_borrow");
        regs[1] = 16'hF0F3; regs[2] = 16'h3C5A;
        applyStimulus(4'd2, 3'd1, 3'd2, "and");
        applyStimulus(4'd3, 3'd1, 3'd2, "or");
        applyStimulus(4'd4, 3'd2, 3'd1, "xor");
        regs[6] = 16'h0001; regs[7] = 16'h0013;
        applyStimulus(4'd5, 3'd6, 3'd7, "shl");
        regs[6] = 16'h8000; regs[7] = 16'hFFFF;
        applyStimulus(4'd6, 3'd6, 3'd7, "shr");
        regs[1] = 16'd5; regs[2] = 16'd9;
        applyStimulus(4'd7, 3'd1, 3'd2, "cmp_lt");
        applyStimulus(4'd7, 3'd2, 3'd1, "cmp_gt");
        applyStimulus(4'd7, 3'd2, 3'd2, "cmp_eq");
        regs[4] = 16'h0003;
        applyStimulus(4'd0, 3'd4, 3'd4, "add_same");
        regs[1] = 16'h0100; regs[2] = 16'h0100;
        applyStimulus(4'd8, 3'd1, 3'd2, "op8");
`ifdef ALU_MUL_EN
        regs[1] = 16'd3; regs[2] = 16'd7;
        applyStimulus(4'd8, 3'd1, 3'd2, "mul_small");
`endif
        regs[1] = 16'hAAAA; regs[2] = 16'h5555;
        applyStimulus(4'd12, 3'd1, 3'd2, "reserved");
        applyStimulus(4'd0, 3'd1, 3'd2, "add_plain");

        repeat (3) @(negedge clk);
        check("hold:result", 32'(result), 32'(lastC));

        // Start held high: three back-to-back instructions, one every 4 cycles.
        regs[6] = 16'h0040; regs[7] = 16'h0011;
        for (int n = 0; n < 3; n++) sb.push_back(model(4'd1, regs[6], regs[7], 3'd6));
        wrExpected += 3;
        start = 1'b1; alu_sel = 4'd1; rx = 3'd6; ry = 3'd7;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 4 == 3) begin
                checkOutput($sformatf("held%0d", k));
            end else begin
                check($sformatf("held%0d:done", k),  32'(done),  32'd0);
                check($sformatf("held%0d:wr_en", k), 32'(wr_en), 32'd0);
            end
            if (k % 4 == 0) check($sformatf("held%0d:busy", k), 32'(busy), 32'd0);
            if (k == 12) start = 1'b0;
        end
        @(negedge clk);
        check("held:idle", 32'(busy), 32'd0);

        // Start pulsed while busy with different operands must be ignored.
        regs[1] = 16'h0FF0; regs[2] = 16'h33CC; regs[5] = 16'h1111;
        sb.push_back(model(4'd2, regs[1], regs[2], 3'd1));
        wrExpected++;
        start = 1'b1; alu_sel = 4'd2; rx = 3'd1; ry = 3'd2;
        @(negedge clk);
        alu_sel = 4'd3; rx = 3'd5; ry = 3'd5;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_start");
        @(negedge clk);
        start = 1'b0;
        check("busy_start:idle4", 32'(busy), 32'd0);
        @(negedge clk);
        check("busy_start:idle5", 32'(busy),  32'd0);
        check("busy_start:wr5",   32'(wr_en), 32'd0);

        // Reset asserted in LOAD_C: abort with no write-back.
        regs[1] = 16'h0007; regs[2] = 16'h0008;
        start = 1'b1; alu_sel = 4'd0; rx = 3'd1; ry = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid:busy_pre", 32'(busy),  32'd1);
        check("rst_mid:mux_pre",  32'(mux_sel), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid:busy",   32'(busy),   32'd0);
        check("rst_mid:result", 32'(result), 32'd0);
        check("rst_mid:carry",  32'(carry),  32'd0);
        check("rst_mid:zero",   32'(zero),   32'd0);
        check("rst_mid:wr_en",  32'(wr_en),  32'd0);
        check("rst_mid:done",   32'(done),   32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_mid:wr%0d", k),   32'(wr_en), 32'd0);
            check($sformatf("rst_mid:busy%0d", k), 32'(busy),  32'd0);
        end

        check("wr_count", 32'(wrSeen), 32'(wrExpected));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
